cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 17 +
 rtl/cdb_arbiter_rr_prio_enc.sv | 38 +++
 rtl/cdb_arbiter.sv | 98 +++++++++
 tb/tb_cdb_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared out-of-order core definitions used by the common data bus arbiter:
// requester indices, reservation-station tag type and wait-counter width.
package cdb_arbiter_pkg;

    localparam int NUM_REQ_DEF = 4;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_BR   = 2;
    localparam int REQ_MUL  = 3;

    localparam int TAG_W  = 5;
    localparam int WAIT_W = 8;

    typedef logic [TAG_W-1:0] RS_tag_type;

endpackage

// File: rtl/cdb_arbiter_rr_prio_enc.sv
// Rotating priority encoder: finds the first set request at or after ptr,
// wrapping modulo N, and returns it both one-hot and as an index.
module rr_prio_enc #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] gnt_idx_o,
    output logic             found_o
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;

    // Walk candidates in rotated order; the extra sum bit keeps the wrap correct for non-power-of-two N.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found_o   = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int off = 0; off < N; off++) begin
            sum = {1'b0, ptr_i} + (PTR_W+1)'(off);
            if (sum >= (PTR_W+1)'(N)) begin
                sum = sum - (PTR_W+1)'(N);
            end
            cand = sum[PTR_W-1:0];
            if (!found_o && req_i[cand]) begin
                found_o      = 1'b1;
                gnt_idx_o    = cand;
                gnt_o[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: grants one functional unit per
// cycle and broadcasts its value and tag with a single cycle of latency.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int XLEN    = 32
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          flush,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0][XLEN-1:0]  req_val,
    input  RS_tag_type [NUM_REQ-1:0]      req_tag,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          cdb_valid,
    output logic [XLEN-1:0]               cdb_val,
    output RS_tag_type                    cdb_tag,
    output logic                          cdb_busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   gnt_idx;
    logic               found;
    logic               grant;

    logic               cdb_valid_q;
    logic [XLEN-1:0]    cdb_val_q;
    RS_tag_type         cdb_tag_q;

    logic [NUM_REQ-1:0][WAIT_W-1:0] wait_q, wait_d;

    rr_prio_enc #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_prio_enc (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .found_o   (found)
    );

    // Grants are suppressed during reset as well as flush so nothing is accepted that will be dropped.
    assign grant     = found && !flush && RST_N;
    assign req_ready = grant ? gnt : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            ptr_d = (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // A flush squashes every pending result, so their waiting history starts over.
    always_comb begin
        wait_d = wait_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (flush || req_ready[i]) begin
                wait_d[i] = '0;
            end else if (req_valid[i] && wait_q[i] != '1) begin
                wait_d[i] = wait_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_val_q   <= '0;
            cdb_tag_q   <= '0;
            wait_q      <= '0;
        end else begin
            ptr_q       <= ptr_d;
            wait_q      <= wait_d;
            cdb_valid_q <= grant;
            if (grant) begin
                cdb_val_q <= req_val[gnt_idx];
                cdb_tag_q <= req_tag[gnt_idx];
            end
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_busy  = cdb_valid_q;
    assign cdb_val   = cdb_val_q;
    assign cdb_tag   = cdb_tag_q;

    // Round-robin bounds any held request's wait to NUM_REQ-1 cycles.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_fair
        assert property (@(posedge CLK) disable iff (!RST_N) wait_q[g] < WAIT_W'(NUM_REQ));
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios then random traffic,
// with expectations from a round-robin reference model kept in this file.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NR   = 4;
    localparam int XLEN = 32;

    typedef struct {
        logic             v;
        logic [XLEN-1:0]  val;
        RS_tag_type       tag;
    } exp_t;

    logic                       CLK;
    logic                       RST_N;
    logic                       flush;
    logic [NR-1:0]              req_valid;
    logic [NR-1:0][XLEN-1:0]    req_val;
    RS_tag_type [NR-1:0]        req_tag;
    logic [NR-1:0]              req_ready;
    logic                       cdb_valid;
    logic [XLEN-1:0]            cdb_val;
    RS_tag_type                 cdb_tag;
    logic                       cdb_busy;

    int nCompared   = 0;
    int nMismatched = 0;

    exp_t expQ[$];

    logic [NR-1:0]           pendValid;
    logic [XLEN-1:0]         pendVal [NR];
    RS_tag_type              pendTag [NR];
    int                      mPtr;
    logic [XLEN-1:0]         mLastVal;
    RS_tag_type              mLastTag;

    cdb_arbiter #(
        .NUM_REQ (NR),
        .XLEN    (XLEN)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .flush     (flush),
        .req_valid (req_valid),
        .req_val   (req_val),
        .req_tag   (req_tag),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_val   (cdb_val),
        .cdb_tag   (cdb_tag),
        .cdb_busy  (cdb_busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rule: scan from the pointer upward, wrapping, and take the first holder.
    function automatic int modelPick(input logic [NR-1:0] v, input int p);
        int order[$];
        for (int k = 0; k < NR; k++) order.push_back((p + k) % NR);
        foreach (order[j]) begin
            if (v[order[j]]) return order[j];
        end
        return -1;
    endfunction

    task automatic setReq(input int i, input logic [XLEN-1:0] v, input RS_tag_type t);
        pendValid[i] = 1'b1;
        pendVal[i]   = v;
        pendTag[i]   = t;
    endtask

    task automatic applyStimulus(input logic doFlush);
        int   g;
        exp_t e;
        @(negedge CLK);
        flush = doFlush;
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = pendValid[i];
            req_val[i]   = pendVal[i];
            req_tag[i]   = pendTag[i];
        end
        #1;
        g = doFlush ? -1 : modelPick(pendValid, mPtr);
        checkOutput("req_ready", req_ready, (g < 0) ? 64'd0 : (64'd1 << g));
        if (g >= 0) begin
            e.v          = 1'b1;
            e.val        = pendVal[g];
            e.tag        = pendTag[g];
            mLastVal     = pendVal[g];
            mLastTag     = pendTag[g];
            mPtr         = (g + 1) % NR;
            pendValid[g] = 1'b0;
        end else begin
            e.v   = 1'b0;
            e.val = mLastVal;
            e.tag = mLastTag;
        end
        expQ.push_back(e);
    endtask

    task automatic applyReset();
        @(negedge CLK);
        RST_N     = 1'b0;
        flush     = 1'b0;
        req_valid = '1;
        #1;
        checkOutput("rst_cdb_valid", cdb_valid, 0);
        checkOutput("rst_cdb_busy", cdb_busy, 0);
        checkOutput("rst_cdb_val", cdb_val, 0);
        checkOutput("rst_cdb_tag", cdb_tag, 0);
        checkOutput("rst_req_ready", req_ready, 0);
        expQ.delete();
        mPtr      = 0;
        mLastVal  = '0;
        mLastTag  = '0;
        pendValid = '0;
        req_valid = '0;
        #2;
        RST_N = 1'b1;
    endtask

    // Monitor: one scoreboard entry per cycle, compared just after the edge it lands on.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("cdb_valid", cdb_valid, e.v);
                checkOutput("cdb_busy", cdb_busy, e.v);
                checkOutput("cdb_val", cdb_val, e.val);
                checkOutput("cdb_tag", cdb_tag, e.tag);
            end
        end
    end

    initial begin
        RST_N     = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        req_val   = '0;
        req_tag   = '0;
        pendValid = '0;
        for (int i = 0; i < NR; i++) begin
            pendVal[i] = '0;
            pendTag[i] = '0;
        end
        mPtr     = 0;
        mLastVal = '0;
        mLastTag = '0;

        applyReset();

        setReq(REQ_LOAD, 32'hDEAD_BEEF, RS_tag_type'(5));
        applyStimulus(1'b0);
        checkOutput("single_load", req_ready, 4'b0010);

        setReq(REQ_BR, 32'h1234_5678, RS_tag_type'(9));
        applyStimulus(1'b0);
        checkOutput("ptr_after_load", req_ready, 4'b0100);

        setReq(REQ_ALU, 32'hA0A0_0001, RS_tag_type'(1));
        setReq(REQ_MUL, 32'hB0B0_0003, RS_tag_type'(3));
        applyStimulus(1'b0);
        checkOutput("wrap_grant3", req_ready, 4'b1000);
        applyStimulus(1'b0);
        checkOutput("wrap_grant0", req_ready, 4'b0001);

        for (int k = 0; k < 3; k++) applyStimulus(1'b0);

        applyReset();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NR; i++) setReq(i, $urandom, RS_tag_type'($urandom_range(0, 31)));
            applyStimulus(1'b0);
            checkOutput("rr_order", req_ready, 64'd1 << (k % NR));
        end

        for (int i = 0; i < NR; i++) setReq(i, $urandom, RS_tag_type'($urandom_range(0, 31)));
        applyStimulus(1'b1);
        checkOutput("flush_ready0", req_ready, 0);
        applyStimulus(1'b1);
        checkOutput("flush_ready1", req_ready, 0);
        applyStimulus(1'b0);
        checkOutput("flush_resume", req_ready, 4'b0001);

        applyReset();
        setReq(REQ_MUL, 32'hCAFE_F00D, RS_tag_type'(7));
        applyStimulus(1'b0);
        applyReset();
        setReq(REQ_LOAD, 32'h1111_2222, RS_tag_type'(11));
        setReq(REQ_BR, 32'h3333_4444, RS_tag_type'(12));
        applyStimulus(1'b0);
        checkOutput("post_reset_grant", req_ready, 4'b0010);

        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pendValid[i] && $urandom_range(0, 1) == 1) begin
                    setReq(i, $urandom, RS_tag_type'($urandom_range(0, 31)));
                end
            end
            applyStimulus(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
        end

        pendValid = '0;
        applyStimulus(1'b0);
        @(negedge CLK);
        @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
